alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single registered ALU between two requesters (req0 = execute stage, req1 = address/aux unit) with one transaction outstanding at a time.
- Accepts an operation over a valid/ready handshake, using round-robin arbitration.
- Drives the ALU operands and opcode, waits the fixed ALU latency, and captures the result.
- Returns the result to the granted requester over a valid/ready response channel.
- Rejects undefined opcodes without touching the ALU.

Parameters:
N, 16, datapath width; matches the ALU operand/result width.
ALU_LAT, 1, clock cycles from the ALU sampling its inputs to alu_out being valid (≥1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
reqX_valid  in  1  requester X (X = 0, 1) has an operation.
reqX_ready  out  1  arbiter accepts requester X's operation this cycle.
reqX_op  in  4  ALU opcode (package encoding).
reqX_a  in  N  operand A.
reqX_b  in  N  operand B.
rspX_valid  out  1  response for requester X is valid.
rspX_ready  in  1  requester X consumes the response.
rspX_data  out  N  ALU result.
rspX_err  out  1  1 = opcode was illegal; data is 0.
alu_a  out  N  ALU operand A.
alu_b  out  N  ALU operand B.
alu_op  out  4  ALU opcode; 4'b0000 (no-op, ALU holds out) when not executing.
alu_out  in  N  ALU result.

Behaviour:
- Reset (rst_n = 0 at a clk edge) forces:
  - state IDLE
  - all reqX_ready, rspX_valid, rspX_err = 0
  - rspX_data = 0
  - alu_a, alu_b, alu_op = 0
  - round-robin pointer = 0 (req0 favoured)
  - latency counter = 0
- Reset mid-transaction abandons the transaction with no response. Reset overrides every other event in the same cycle.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational and nonzero only in IDLE.
  - ready0 = valid0 & (ptr == 0 | !valid1); ready1 = valid1 & (ptr == 1 | !valid0).
  - At most one ready is high.
  - On an accepting edge (valid & ready):
    - latch the granted id, op, a and b;
    - set ptr to the other requester;
    - if op is legal: go to EXEC and load the counter with ALU_LAT;
    - if op is illegal: go directly to RESP with err = 1 and data = 0, never issuing to the ALU.
- EXEC:
  - alu_a, alu_b and alu_op are registered and stable with the latched values for ALU_LAT + 1 cycles.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, alu_out is valid: capture it into the granted rsp_data, set err = 0, and go to RESP.
  - On leaving EXEC, alu_op returns to 0.
- RESP:
  - Only the granted rspX_valid = 1; data and err are held stable until rspX_ready.
  - On the edge with valid & ready: rspX_valid drops and the block goes to IDLE.
  - The next request may be accepted no earlier than the following cycle; there is no bypass.
- Latency:
  - Legal op, rsp ready tied high: acceptance edge → rsp_valid high after ALU_LAT + 2 edges (3 with ALU_LAT = 1).
  - Illegal op: rsp_valid high one edge after acceptance.
- Results are passed through unmodified. Width is N everywhere, with no extension or truncation. SEQ/SLT results arrive as produced by the ALU.
- Requests arriving while busy see ready = 0 and must hold valid. Round-robin fairness is evaluated only in IDLE.
- A requester dropping valid before acceptance is legal. Dropping valid after acceptance has no effect.

Decomposition:
- Package alu_pkg holds:
  - opcode constants ALU_ADD = 4'b0001, ALU_OR = 4'b0010, ALU_AND = 4'b0100, ALU_XOR = 4'b1000, ALU_SL = 4'b0011, ALU_SR = 4'b0101, ALU_SEQ = 4'b0110, ALU_SLT = 4'b1001, ALU_NOP = 4'b0000;
  - function op_legal (true for the eight defined opcodes);
  - state encoding constants.
- One sub-module, rr_arb2: the 2-way round-robin pointer plus ready generation.
- The FSM, counter and datapath latches live in alu_arbiter.

Test Plan:
- Single legal op: req0 ADD a = 16'h0003, b = 16'h0004, rsp0_ready = 1 → req0_ready for 1 cycle; alu_op = 4'b0001 for 2 cycles; rsp0_valid 3 edges after acceptance with data = 16'h0007, err = 0; rsp1_valid stays 0.
- Contention: both valid every cycle, req0 XOR 16'hFF00 ^ 16'h0FF0, req1 OR 16'h00F0 | 16'h000F → grants alternate 0, 1, 0, 1 starting with req0 after reset; responses 16'hF0F0 to req0 and 16'h00FF to req1; never both ready high.
- Illegal opcode 4'b1111 on req1 → accepted; alu_op stays 0; rsp1_valid one edge later with err = 1 and data = 0; ptr flips to 0.
- Backpressure: rsp0_ready held 0 for 5 cycles → rsp0_valid and data stable all 5 cycles; both req readies stay 0; release → IDLE next edge, then the next grant.
- Reset mid-EXEC: assert rst_n = 0 during the second EXEC cycle → next edge: all outputs 0, no response ever issued, ptr = 0; a fresh req0 SLT 16'h0001 < 16'h0002 completes with data = 16'h0001.
- ALU_LAT = 3 build: single AND 16'h0F0F & 16'h00FF → alu_op held 4 cycles; rsp_valid 5 edges after acceptance with data = 16'h000F.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encoding, legality check and
// FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SL  = 4'b0011;
  localparam logic [3:0] ALU_SR  = 4'b0101;
  localparam logic [3:0] ALU_SEQ = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_OR, ALU_AND, ALU_XOR,
      ALU_SL, ALU_SR, ALU_SEQ, ALU_SLT: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: ready generation plus the favour pointer,
// which always points away from the most recently granted requester.
module rr_arb2
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1
);

  logic ptr;

  // Grant the favoured requester, or whichever one is alone in asking.
  always_comb begin
    ready0 = en & valid0 & (~ptr | ~valid1);
    ready1 = en & valid1 & (ptr | ~valid0);
  end

  // Pointer flips to the other requester on every accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (ready0) begin
      ptr <= 1'b1;
    end else if (ready1) begin
      ptr <= 1'b0;
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters, one transaction at a time:
// accept, execute for a fixed latency, then hold the response until consumed.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N       = 16,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_data,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_data,
  output logic         rsp1_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_out
);

  localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  state_t         state, state_nxt;
  logic           gnt, gnt_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   alu_a_nxt, alu_b_nxt;
  logic [3:0]     alu_op_nxt;
  logic           rsp0_valid_nxt, rsp1_valid_nxt;
  logic           rsp0_err_nxt, rsp1_err_nxt;
  logic [N-1:0]   rsp0_data_nxt, rsp1_data_nxt;
  logic           arb_en;
  logic [3:0]     sel_op;
  logic [N-1:0]   sel_a, sel_b;

  assign arb_en = (state == ST_IDLE);

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (arb_en),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ready0 (req0_ready),
    .ready1 (req1_ready)
  );

  // Route the granted requester's operation into the latch path.
  always_comb begin
    if (req1_ready) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end else begin
      sel_op = req0_op;
      sel_a  = req0_a;
      sel_b  = req0_b;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-value logic; every register holds unless told otherwise.
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    cnt_nxt        = cnt;
    alu_a_nxt      = alu_a;
    alu_b_nxt      = alu_b;
    alu_op_nxt     = alu_op;
    rsp0_valid_nxt = rsp0_valid;
    rsp1_valid_nxt = rsp1_valid;
    rsp0_err_nxt   = rsp0_err;
    rsp1_err_nxt   = rsp1_err;
    rsp0_data_nxt  = rsp0_data;
    rsp1_data_nxt  = rsp1_data;
    case (state)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          gnt_nxt = req1_ready;
          if (op_legal(sel_op)) begin
            state_nxt  = ST_EXEC;
            cnt_nxt    = CW'(ALU_LAT);
            alu_a_nxt  = sel_a;
            alu_b_nxt  = sel_b;
            alu_op_nxt = sel_op;
          end else if (req1_ready) begin
            // Illegal opcodes bypass the ALU and answer with an error.
            state_nxt      = ST_RESP;
            rsp1_valid_nxt = 1'b1;
            rsp1_err_nxt   = 1'b1;
            rsp1_data_nxt  = {N{1'b0}};
          end else begin
            state_nxt      = ST_RESP;
            rsp0_valid_nxt = 1'b1;
            rsp0_err_nxt   = 1'b1;
            rsp0_data_nxt  = {N{1'b0}};
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt == {CW{1'b0}}) begin
          state_nxt  = ST_RESP;
          alu_op_nxt = ALU_NOP;
          if (gnt) begin
            rsp1_valid_nxt = 1'b1;
            rsp1_err_nxt   = 1'b0;
            rsp1_data_nxt  = alu_out;
          end else begin
            rsp0_valid_nxt = 1'b1;
            rsp0_err_nxt   = 1'b0;
            rsp0_data_nxt  = alu_out;
          end
        end else begin
          cnt_nxt = cnt - CW'(1'b1);
        end
      end
      ST_RESP: begin
        if (gnt && rsp1_ready) begin
          rsp1_valid_nxt = 1'b0;
          state_nxt      = ST_IDLE;
        end else if (!gnt && rsp0_ready) begin
          rsp0_valid_nxt = 1'b0;
          state_nxt      = ST_IDLE;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt        <= 1'b0;
      cnt        <= {CW{1'b0}};
      alu_a      <= {N{1'b0}};
      alu_b      <= {N{1'b0}};
      alu_op     <= ALU_NOP;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_err   <= 1'b0;
      rsp1_err   <= 1'b0;
      rsp0_data  <= {N{1'b0}};
      rsp1_data  <= {N{1'b0}};
    end else begin
      gnt        <= gnt_nxt;
      cnt        <= cnt_nxt;
      alu_a      <= alu_a_nxt;
      alu_b      <= alu_b_nxt;
      alu_op     <= alu_op_nxt;
      rsp0_valid <= rsp0_valid_nxt;
      rsp1_valid <= rsp1_valid_nxt;
      rsp0_err   <= rsp0_err_nxt;
      rsp1_err   <= rsp1_err_nxt;
      rsp0_data  <= rsp0_data_nxt;
      rsp1_data  <= rsp1_data_nxt;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random traffic
// against a transaction-level model, and a second instance built with ALU_LAT = 3.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N   = 16;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [N-1:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_out;
  logic [3:0]   alu_op;

  logic         x_req0_valid, x_req0_ready, x_req1_valid, x_req1_ready;
  logic [3:0]   x_req0_op, x_req1_op;
  logic [N-1:0] x_req0_a, x_req0_b, x_req1_a, x_req1_b;
  logic         x_rsp0_valid, x_rsp0_ready, x_rsp0_err, x_rsp1_valid, x_rsp1_ready, x_rsp1_err;
  logic [N-1:0] x_rsp0_data, x_rsp1_data, x_alu_a, x_alu_b, x_alu_out, x_st1, x_st2;
  logic [3:0]   x_alu_op;

  alu_arbiter #(.N(N), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
  );

  alu_arbiter #(.N(N), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_op(x_req0_op), .req0_a(x_req0_a), .req0_b(x_req0_b),
    .req1_valid(x_req1_valid), .req1_ready(x_req1_ready), .req1_op(x_req1_op), .req1_a(x_req1_a), .req1_b(x_req1_b),
    .rsp0_valid(x_rsp0_valid), .rsp0_ready(x_rsp0_ready), .rsp0_data(x_rsp0_data), .rsp0_err(x_rsp0_err),
    .rsp1_valid(x_rsp1_valid), .rsp1_ready(x_rsp1_ready), .rsp1_data(x_rsp1_data), .rsp1_err(x_rsp1_err),
    .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_op(x_alu_op), .alu_out(x_alu_out)
  );

  // Behavioural ALU: what a correct result looks like for each opcode.
  function automatic logic [N-1:0] alu_calc(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_XOR: return a ^ b;
      ALU_SL:  return a << b[3:0];
      ALU_SR:  return a >> b[3:0];
      ALU_SEQ: return (a == b) ? 16'd1 : 16'd0;
      ALU_SLT: return (a < b) ? 16'd1 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  function automatic bit is_defined(input logic [3:0] op);
    return op inside {ALU_ADD, ALU_OR, ALU_AND, ALU_XOR, ALU_SL, ALU_SR, ALU_SEQ, ALU_SLT};
  endfunction

  // Registered ALUs: latency 1 for dut, latency 3 for dut3; a no-op holds the output.
  always @(posedge clk) begin
    if (alu_op != ALU_NOP) alu_out <= alu_calc(alu_op, alu_a, alu_b);
    if (x_alu_op != ALU_NOP) x_st1 <= alu_calc(x_alu_op, x_alu_a, x_alu_b);
    x_st2     <= x_st1;
    x_alu_out <= x_st2;
  end

  typedef struct {
    int           id;
    logic [3:0]   op;
    logic [N-1:0] a, b, data;
    logic         err;
    int           acc;
  } txn_t;

  txn_t         sb[$];
  int           gnt_log[$];
  int           checks = 0, errors = 0, cyc = 0, n_done = 0, favour = 0, alu_cyc = 0;
  bit           busy = 1'b0, seen = 1'b0, post_rst = 1'b0, exp0, exp1;
  bit           accd[2];
  logic [N-1:0] last_data[2];
  logic         last_err[2];
  logic [N-1:0] d;
  logic         e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor and scoreboard for dut, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      busy     = 1'b0;
      favour   = 0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        post_rst = 1'b0;
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_rsp_err", {30'd0, rsp1_err, rsp0_err}, 32'd0);
        chk("rst_rsp_data", {rsp1_data, rsp0_data}, 32'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
      end
      exp0 = !busy && req0_valid && (favour == 0 || !req1_valid);
      exp1 = !busy && req1_valid && (favour == 1 || !req0_valid);
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, exp0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, exp1});
      if (busy) begin
        if (alu_op != ALU_NOP) begin
          alu_cyc++;
          chk("alu_op", {28'd0, alu_op}, {28'd0, sb[0].op});
          chk("alu_ab", {alu_a, alu_b}, {sb[0].a, sb[0].b});
        end
        if (rsp0_valid || rsp1_valid) begin
          chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, sb[0].id == 0});
          chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, sb[0].id == 1});
          d = (sb[0].id == 1) ? rsp1_data : rsp0_data;
          e = (sb[0].id == 1) ? rsp1_err : rsp0_err;
          chk("rsp_data", {16'd0, d}, {16'd0, sb[0].data});
          chk("rsp_err", {31'd0, e}, {31'd0, sb[0].err});
          if (!seen) begin
            seen = 1'b1;
            chk("rsp_latency", cyc - sb[0].acc, sb[0].err ? 0 : LAT + 1);
            chk("alu_cycles", alu_cyc, sb[0].err ? 0 : LAT + 1);
          end
          if ((sb[0].id == 1) ? rsp1_ready : rsp0_ready) begin
            last_data[sb[0].id] = d;
            last_err[sb[0].id]  = e;
            void'(sb.pop_front());
            busy = 1'b0;
            n_done++;
          end
        end else if (cyc - sb[0].acc > 40) begin
          fail("rsp_timeout");
          sb.delete();
          busy = 1'b0;
        end
      end else begin
        chk("alu_op_idle", {28'd0, alu_op}, 32'd0);
        chk("rsp_spurious", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        txn_t t;
        t.id   = (req0_valid && req0_ready) ? 0 : 1;
        t.op   = t.id ? req1_op : req0_op;
        t.a    = t.id ? req1_a : req0_a;
        t.b    = t.id ? req1_b : req0_b;
        t.err  = !is_defined(t.op);
        t.data = t.err ? 16'd0 : alu_calc(t.op, t.a, t.b);
        t.acc  = cyc + 1;
        sb.push_back(t);
        gnt_log.push_back(t.id);
        accd[t.id] = 1'b1;
        favour     = 1 - t.id;
        busy       = 1'b1;
        seen       = 1'b0;
        alu_cyc    = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    accd[id] = 1'b0;
    if (id == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int i;
    set_req(id, op, a, b);
    for (i = 0; i < 60 && !accd[id]; i++) tick();
    if (!accd[id]) fail("accept_timeout");
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 80 && busy; i++) tick();
    if (busy) fail("idle_timeout");
    tick();
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] op_tab [10];
    bit         pend[2];
    int         k, acnt, lat3;
    op_tab = '{ALU_ADD, ALU_OR, ALU_AND, ALU_XOR, ALU_SL, ALU_SR, ALU_SEQ, ALU_SLT, 4'hF, 4'h7};
    rst_n = 1'b0;
    alu_out = 16'd0; x_st1 = 16'd0; x_st2 = 16'd0; x_alu_out = 16'd0;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 16'd0; req0_b = 16'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 16'd0; req1_b = 16'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    x_req0_valid = 1'b0; x_req0_op = 4'd0; x_req0_a = 16'd0; x_req0_b = 16'd0;
    x_req1_valid = 1'b0; x_req1_op = 4'd0; x_req1_a = 16'd0; x_req1_b = 16'd0;
    x_rsp0_ready = 1'b1; x_rsp1_ready = 1'b1;
    do_reset();

    // Single legal operation.
    issue(0, ALU_ADD, 16'h0003, 16'h0004);
    wait_idle();
    chk("add_data", {16'd0, last_data[0]}, 32'h0007);
    chk("add_err", {31'd0, last_err[0]}, 32'd0);

    // Contention from reset: grants alternate starting with req0.
    do_reset();
    gnt_log.delete();
    set_req(0, ALU_XOR, 16'hFF00, 16'h0FF0);
    set_req(1, ALU_OR, 16'h00F0, 16'h000F);
    for (k = 0; k < 80 && gnt_log.size() < 4; k++) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("contention_grants", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("contention_order", gnt_log[i], i % 2);
    chk("xor_data", {16'd0, last_data[0]}, 32'hF0F0);
    chk("or_data", {16'd0, last_data[1]}, 32'h00FF);

    // Illegal opcode on req1 after a req0 grant: error reply, pointer back to req0.
    issue(0, ALU_AND, 16'h1234, 16'h00FF);
    wait_idle();
    issue(1, 4'hF, 16'hABCD, 16'h1111);
    wait_idle();
    chk("illegal_err", {31'd0, last_err[1]}, 32'd1);
    chk("illegal_data", {16'd0, last_data[1]}, 32'd0);
    gnt_log.delete();
    set_req(0, ALU_ADD, 16'h0001, 16'h0001);
    set_req(1, ALU_ADD, 16'h0002, 16'h0002);
    for (k = 0; k < 20 && gnt_log.size() < 1; k++) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("ptr_after_illegal", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

    // Backpressure: response held for 5 cycles while req1 waits.
    rsp0_ready = 1'b0;
    issue(0, ALU_SL, 16'h0011, 16'h0004);
    set_req(1, ALU_SR, 16'h8000, 16'h0003);
    for (k = 0; k < 20 && !rsp0_valid; k++) tick();
    for (k = 0; k < 5; k++) tick();
    rsp0_ready = 1'b1;
    for (k = 0; k < 20 && !accd[1]; k++) tick();
    req1_valid = 1'b0;
    wait_idle();
    chk("bp_data", {16'd0, last_data[0]}, 32'h0110);
    chk("bp_next_grant", {16'd0, last_data[1]}, 32'h1000);

    // Reset during the second EXEC cycle abandons the transaction.
    issue(0, ALU_SLT, 16'h0005, 16'h0009);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    k = n_done;
    issue(0, ALU_SLT, 16'h0001, 16'h0002);
    wait_idle();
    chk("slt_after_reset", {16'd0, last_data[0]}, 32'h0001);
    chk("responses_after_reset", n_done - k, 1);

    // Random traffic.
    k = n_done;
    pend = '{1'b0, 1'b0};
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (pend[r] && accd[r]) begin
          pend[r] = 1'b0;
          if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end else if (pend[r] && $urandom_range(0, 15) == 0) begin
          pend[r] = 1'b0;
          if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end else if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          set_req(r, op_tab[$urandom_range(0, 9)], 16'($urandom_range(0, 65535)),
                  ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 65535)));
        end
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    wait_idle();
    chk("random_progress", {31'd0, (n_done - k) >= 20}, 32'd1);

    // ALU_LAT = 3 instance: one AND operation.
    x_req0_op = ALU_AND; x_req0_a = 16'h0F0F; x_req0_b = 16'h00FF; x_req0_valid = 1'b1;
    @(negedge clk);
    chk("lat3_ready", {31'd0, x_req0_ready}, 32'd1);
    tick();
    x_req0_valid = 1'b0;
    acnt = 0; lat3 = 0;
    for (k = 1; k <= 20 && lat3 == 0; k++) begin
      @(negedge clk);
      if (x_alu_op != ALU_NOP) begin
        acnt++;
        chk("lat3_alu_op", {28'd0, x_alu_op}, {28'd0, ALU_AND});
      end
      if (x_rsp0_valid) begin
        lat3 = k;
        chk("lat3_data", {16'd0, x_rsp0_data}, 32'h000F);
        chk("lat3_err", {31'd0, x_rsp0_err}, 32'd0);
      end
    end
    if (lat3 == 0) fail("lat3_rsp_timeout");
    chk("lat3_latency", lat3, 5);
    chk("lat3_alu_cycles", acnt, 4);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
